// File: rtl/dac_mux_pkg.sv
// Shared types and constants for the DAC7611 / 8-way mux scan controller.
// FSM encoding, DAC pin indices, timing constants and channel-search helpers.
package dac_mux_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_LD_SETUP,
      S_LOAD,
      S_SETTLE,
      S_DWELL,
      S_GAP
   } scan_state_e;

   localparam int CLK_IDX = 3;
   localparam int SDI_IDX = 2;
   localparam int LD_IDX  = 1;
   localparam int CLR_IDX = 0;

   localparam int DAC_BITS  = 12;
   localparam int NUM_CH    = 8;
   localparam int BIT_CYC   = 4;
   localparam int LD_CYC    = 2;
   localparam int SHIFT_CYC = DAC_BITS * BIT_CYC;
   localparam int SER_LAST  = SHIFT_CYC + 2 * LD_CYC - 1;

   localparam logic [3:0] DAC_IDLE = 4'b1111;

   // lowest enabled channel
   function automatic logic [2:0] lowest_ch(
      input logic [NUM_CH-1:0] mask
   );
      logic [2:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i]) r = i[2:0];
      return r;
   endfunction

   // {wrapped, ch}: next enabled channel above cur, wrapping 7->0
   function automatic logic [3:0] next_ch(
      input logic [NUM_CH-1:0] mask,
      input logic [2:0]        cur
   );
      logic [3:0] r;
      logic [3:0] idx;
      logic       found;
      r     = {1'b1, cur};
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = {1'b0, cur} + i[3:0];
         if (!found && mask[idx[2:0]]) begin
            found = 1'b1;
            r     = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dac_mux_scan_ctrl_serializer.sv
// DAC7611 serial loader: 12 bits MSB first at clk/4, LD setup and LD pulse.
// Runs 52 cycles after go; pins rest at idle level otherwise.
module dac7611_serializer
   import dac_mux_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic [DAC_BITS-1:0] code,
   output logic                sclk,
   output logic                sdi,
   output logic                ld,
   output logic                done
);

   logic                busy_q, busy_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [DAC_BITS-1:0] sr_q, sr_d;
   logic                shifting;

   // latch code on go, then step the bit/phase counter
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      sr_d   = sr_q;
      if (go) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         sr_d   = code;
      end else if (busy_q) begin
         cnt_d = cnt_q + 6'd1;
         if (shifting && cnt_q[1:0] == 2'(BIT_CYC - 1))
            sr_d = {sr_q[DAC_BITS-2:0], 1'b0};
         if (cnt_q == 6'(SER_LAST)) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   // serializer state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         sr_q   <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         sr_q   <= sr_d;
      end
   end

   assign shifting = busy_q && (cnt_q < 6'(SHIFT_CYC));
   assign sclk = shifting ? cnt_q[1] : 1'b1;
   assign sdi  = shifting ? sr_q[DAC_BITS-1] : 1'b1;
   assign ld   = !(busy_q && cnt_q >= 6'(SHIFT_CYC + LD_CYC));
   assign done = busy_q && (cnt_q == 6'(SER_LAST));

endmodule

// File: rtl/dac_mux_scan_ctrl.sv
// Scan scheduler: per-channel DAC load, settle, mux dwell, gap, clear.
// Define DAC_SCAN_STATS_EN to add the scan_count pass counter output.
module dac_mux_scan_ctrl
   import dac_mux_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 20,
   parameter int unsigned DWELL_CYC  = 100,
   parameter int unsigned GAP_CYC    = 4,
   parameter int unsigned CLR_CYC    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [2:0]          wr_ch,
   input  logic [DAC_BITS-1:0] wr_data,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic                start,
   input  logic                continuous,
   input  logic                stop,
   input  logic                clr_req,
   output logic [3:0]          dac_signals_4,
   output logic [NUM_CH-1:0]   mux_signals,
   output logic                busy,
   output logic [2:0]          cur_ch,
   output logic                ch_done
`ifdef DAC_SCAN_STATS_EN
   ,
   output logic [15:0]         scan_count
`endif
);

   scan_state_e         state_q, state_d;
   logic [9:0]          cnt_q, cnt_d;
   logic [2:0]          ch_q, ch_d, nch_q, nch_d;
   logic                aclr_q, aclr_d;
   logic                clr_pend_q, clr_pend_d;
   logic                stop_pend_q, stop_pend_d;
   logic [DAC_BITS-1:0] codes_q [NUM_CH];
   logic [DAC_BITS-1:0] codes_d [NUM_CH];
   logic                go, cnt_z, clr_eff, stop_eff, boundary;
   logic [3:0]          nxt;
   logic                ser_clk, ser_sdi, ser_ld, ser_done;

   assign cnt_z    = (cnt_q == '0);
   assign clr_eff  = clr_pend_q | clr_req;
   assign stop_eff = stop_pend_q | stop;
   assign nxt      = next_ch(ch_mask, ch_q);
   assign boundary = (state_q == S_GAP) && cnt_z;

   dac7611_serializer u_ser (
      .clk   (clk),
      .reset (reset),
      .go    (go),
      .code  (codes_q[ch_d]),
      .sclk  (ser_clk),
      .sdi   (ser_sdi),
      .ld    (ser_ld),
      .done  (ser_done)
   );

   // code RAM writes and pending clear/stop latches
   always_comb begin
      codes_d = codes_q;
      if (wr_en) codes_d[wr_ch] = wr_data;
      clr_pend_d  = clr_eff &&
                    !(state_d == S_CLEAR && state_q != S_CLEAR);
      stop_pend_d = stop_eff && (state_q != S_IDLE) &&
                    (state_d != S_IDLE);
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ch_q        <= '0;
         nch_q       <= '0;
         aclr_q      <= 1'b0;
         clr_pend_q  <= 1'b0;
         stop_pend_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) codes_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         nch_q       <= nch_d;
         aclr_q      <= aclr_d;
         clr_pend_q  <= clr_pend_d;
         stop_pend_q <= stop_pend_d;
         codes_q     <= codes_d;
      end
   end

   // next state, phase timer and channel scheduling
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_z ? cnt_q : cnt_q - 10'd1;
      ch_d    = ch_q;
      nch_d   = nch_q;
      aclr_d  = aclr_q;
      go      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (clr_eff) begin
               state_d = S_CLEAR;
               cnt_d   = 10'(CLR_CYC - 1);
               aclr_d  = 1'b0;
            end else if (start && !stop && ch_mask != '0) begin
               state_d = S_SHIFT;
               cnt_d   = 10'(SHIFT_CYC - 1);
               ch_d    = lowest_ch(ch_mask);
               go      = 1'b1;
            end
         end
         S_CLEAR: begin
            if (cnt_z) begin
               if (aclr_q) begin
                  state_d = S_SHIFT;
                  cnt_d   = 10'(SHIFT_CYC - 1);
                  ch_d    = nch_q;
                  go      = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  ch_d    = '0;
               end
            end
         end
         S_SHIFT: if (cnt_z) begin
            state_d = S_LD_SETUP;
            cnt_d   = 10'(LD_CYC - 1);
         end
         S_LD_SETUP: if (cnt_z) begin
            state_d = S_LOAD;
            cnt_d   = 10'(LD_CYC - 1);
         end
         S_LOAD: if (ser_done) begin
            state_d = S_SETTLE;
            cnt_d   = 10'(SETTLE_CYC - 1);
         end
         S_SETTLE: if (cnt_z) begin
            state_d = S_DWELL;
            cnt_d   = 10'(DWELL_CYC - 1);
         end
         S_DWELL: if (cnt_z) begin
            state_d = S_GAP;
            cnt_d   = 10'(GAP_CYC - 1);
         end
         S_GAP: begin
            if (cnt_z) begin
               if (stop_eff || ch_mask == '0) begin
                  state_d = S_IDLE;
                  ch_d    = '0;
               end else if (clr_eff) begin
                  state_d = S_CLEAR;
                  cnt_d   = 10'(CLR_CYC - 1);
                  nch_d   = nxt[2:0];
                  aclr_d  = !(nxt[3] && !continuous);
               end else if (nxt[3] && !continuous) begin
                  state_d = S_IDLE;
                  ch_d    = '0;
               end else begin
                  state_d = S_SHIFT;
                  cnt_d   = 10'(SHIFT_CYC - 1);
                  ch_d    = nxt[2:0];
                  go      = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pin and status outputs from current state
   always_comb begin
      dac_signals_4          = DAC_IDLE;
      dac_signals_4[CLK_IDX] = ser_clk;
      dac_signals_4[SDI_IDX] = ser_sdi;
      dac_signals_4[LD_IDX]  = ser_ld;
      dac_signals_4[CLR_IDX] = (state_q != S_CLEAR);
      mux_signals = '0;
      if (state_q == S_DWELL) mux_signals[ch_q] = 1'b1;
      busy    = (state_q != S_IDLE);
      cur_ch  = ch_q;
      ch_done = boundary;
   end

`ifdef DAC_SCAN_STATS_EN
   logic [15:0] scnt_q, scnt_d;
   logic        pass_done;

   assign pass_done = boundary && !stop_eff &&
                      (ch_mask != '0) && nxt[3];

   // count completed passes
   always_comb begin
      scnt_d = scnt_q + 16'(pass_done);
   end

   // pass counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) scnt_q <= '0;
      else        scnt_q <= scnt_d;
   end

   assign scan_count = scnt_q;
`endif

endmodule

// File: tb/tb_dac_mux_scan_ctrl.sv
// Self-checking bench for dac_mux_scan_ctrl: vector table, sequences,
// and randomized scans against a per-frame waveform model.
module tb_dac_mux_scan_ctrl;

   localparam int SETTLE = 20;
   localparam int DWELL  = 100;
   localparam int GAP    = 4;
   localparam int FRAME  = 52 + SETTLE + DWELL + GAP;
   localparam int DW_ON  = 52 + SETTLE;
   localparam int DW_OFF = DW_ON + DWELL;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_ch = '0;
   logic [11:0] wr_data = '0;
   logic [7:0]  ch_mask = '0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        stop = 1'b0;
   logic        clr_req = 1'b0;
   logic [3:0]  dac;
   logic [7:0]  mux;
   logic        busy;
   logic [2:0]  cur_ch;
   logic        ch_done;
`ifdef DAC_SCAN_STATS_EN
   logic [15:0] scan_count;
`endif

   always #5 clk = ~clk;

   dac_mux_scan_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_ch         (wr_ch),
      .wr_data       (wr_data),
      .ch_mask       (ch_mask),
      .start         (start),
      .continuous    (continuous),
      .stop          (stop),
      .clr_req       (clr_req),
      .dac_signals_4 (dac),
      .mux_signals   (mux),
      .busy          (busy),
      .cur_ch        (cur_ch),
`ifdef DAC_SCAN_STATS_EN
      .scan_count    (scan_count),
`endif
      .ch_done       (ch_done)
   );

   typedef struct packed {
      logic [3:0] dac;
      logic [7:0] mux;
      logic       busy;
      logic [2:0] ch;
      logic       done;
   } obs_t;

   typedef struct {
      logic        wr;
      int          ch;
      logic [11:0] code;
      logic [11:0] exp_word;
      logic [7:0]  exp_mux;
      int          exp_ld_at;
      int          exp_mux_at;
   } vec_t;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [11:0] mcode [8];

   // expected pins/status at cycle t of a frame for channel ch
   function automatic obs_t model(input logic [11:0] code,
                                  input int ch, input int t);
      obs_t o;
      o.dac  = 4'hF;
      o.mux  = 8'h00;
      o.busy = 1'b1;
      o.ch   = ch[2:0];
      o.done = (t == FRAME - 1);
      if (t < 48) begin
         o.dac[2] = code[11 - t / 4];
         o.dac[3] = (t % 4) >= 2;
      end else if (t >= 50 && t < 52) begin
         o.dac[1] = 1'b0;
      end else if (t >= DW_ON && t < DW_OFF) begin
         o.mux = 8'(1 << ch);
      end
      return o;
   endfunction

   function automatic obs_t now_obs();
      return {dac, mux, busy, cur_ch, ch_done};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int ch, input logic [11:0] d);
      wr_en   = 1'b1;
      wr_ch   = ch[2:0];
      wr_data = d;
      mcode[ch] = d;
      tick;
      wr_en = 1'b0;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic chk_idle(input string nm);
      chk(nm, 32'(now_obs()), 32'({4'hF, 8'h00, 1'b0, 3'd0, 1'b0}));
   endtask

   // kind: 1 stop, 2 start, 3 clr_req, 4 write pdata to ch
   task automatic run_frame(input logic [11:0] code, input int ch,
                            input string nm, input int pt,
                            input int kind, input logic [11:0] pdata);
      obs_t a, e, ba, be;
      int   bad;
      bad = -1;
      ba  = '0;
      be  = '0;
      for (int t = 0; t < FRAME; t++) begin
         a = now_obs();
         e = model(code, ch, t);
         if (a !== e && bad < 0) begin
            bad = t;
            ba  = a;
            be  = e;
         end
         if (t == pt) begin
            case (kind)
               1: stop = 1'b1;
               2: start = 1'b1;
               3: clr_req = 1'b1;
               4: begin
                  wr_en = 1'b1;
                  wr_ch = ch[2:0];
                  wr_data = pdata;
                  mcode[ch] = pdata;
               end
               default: ;
            endcase
         end
         tick;
         stop = 1'b0;
         start = 1'b0;
         clr_req = 1'b0;
         wr_en = 1'b0;
      end
      n_chk++;
      if (bad < 0) n_pass++;
      else $display("FAIL %s ch%0d t=%0d: got %h, want %h",
                    nm, ch, bad, ba, be);
   endtask

   initial begin
      vec_t        vt [5];
      logic [11:0] word;
      int          nb, ld_at, ldn, mux_at, muxn, dn, clrn;
      logic        pclk;
      logic [7:0]  muxv;
      int          q[$];
      logic [7:0]  msk;
      logic        cont;
      int          npass, last;

      vt[0] = '{1'b0, 0, 12'h000, 12'h000, 8'h01, 50, DW_ON};
      vt[1] = '{1'b1, 2, 12'h5A5, 12'h5A5, 8'h04, 50, DW_ON};
      vt[2] = '{1'b1, 7, 12'hFFF, 12'hFFF, 8'h80, 50, DW_ON};
      vt[3] = '{1'b1, 5, 12'h801, 12'h801, 8'h20, 50, DW_ON};
      vt[4] = '{1'b1, 3, 12'h3C6, 12'h3C6, 8'h08, 50, DW_ON};
      for (int i = 0; i < 8; i++) mcode[i] = '0;

      repeat (3) tick;
      chk_idle("reset_state");
      reset = 1'b1;
      tick;

      for (int i = 0; i < 5; i++) begin
         if (vt[i].wr) write(vt[i].ch, vt[i].code);
         ch_mask = 8'(1 << vt[i].ch);
         continuous = 1'b0;
         pulse_start;
         word = '0; nb = 0; pclk = 1'b1; ld_at = -1; ldn = 0;
         mux_at = -1; muxn = 0; muxv = '0; dn = 0; clrn = 0;
         for (int t = 0; t < FRAME + 4; t++) begin
            if (!pclk && dac[3]) begin
               word = {word[10:0], dac[2]};
               nb++;
            end
            pclk = dac[3];
            if (!dac[1]) begin
               if (ld_at < 0) ld_at = t;
               ldn++;
            end
            if (mux != 8'h00) begin
               if (mux_at < 0) begin
                  mux_at = t;
                  muxv = mux;
               end
               muxn++;
            end
            if (ch_done) dn++;
            if (!dac[0]) clrn++;
            tick;
         end
         chk("vec_sdi_word", 32'(word), 32'(vt[i].exp_word));
         chk("vec_sdi_bits", nb, 12);
         chk("vec_ld_at", ld_at, vt[i].exp_ld_at);
         chk("vec_ld_len", ldn, 2);
         chk("vec_mux_at", mux_at, vt[i].exp_mux_at);
         chk("vec_mux_val", 32'(muxv), 32'(vt[i].exp_mux));
         chk("vec_mux_len", muxn, DWELL);
         chk("vec_ch_done", dn, 1);
         chk("vec_no_clr", clrn, 0);
         chk("vec_end_busy", 32'(busy), 0);
      end

      write(0, 12'h111);
      write(7, 12'h777);
      ch_mask = 8'h81;
      continuous = 1'b1;
      pulse_start;
      run_frame(mcode[0], 0, "cont_f0", 60, 2, '0);
      run_frame(mcode[7], 7, "cont_f1", -1, 0, '0);
      run_frame(mcode[0], 0, "cont_f2", -1, 0, '0);
      run_frame(mcode[7], 7, "cont_f3", 30, 1, '0);
      chk_idle("cont_stop_idle");

      continuous = 1'b0;
      write(1, 12'h1A1);
      write(4, 12'h4B4);
      ch_mask = 8'h12;
      pulse_start;
      run_frame(mcode[1], 1, "clr_f0", 10, 3, '0);
      for (int k = 0; k < 2; k++) begin
         chk("clr_boundary", 32'({dac, mux, busy}),
             32'({4'hE, 8'h00, 1'b1}));
         tick;
      end
      run_frame(mcode[4], 4, "clr_f1", -1, 0, '0);
      chk_idle("clr_end_idle");
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("clr_idle", 32'({dac, mux, busy}),
             32'({4'hE, 8'h00, 1'b1}));
         tick;
      end
      chk_idle("clr_idle_done");

      write(3, 12'h0F0);
      ch_mask = 8'h08;
      continuous = 1'b1;
      pulse_start;
      run_frame(mcode[3], 3, "wr_old", 100, 4, 12'hF0F);
      run_frame(mcode[3], 3, "wr_new", 5, 1, '0);
      chk_idle("wr_idle");
      continuous = 1'b0;

      ch_mask = 8'h00;
      pulse_start;
      repeat (3) tick;
      chk("mask0_busy", 32'(busy), 0);
      ch_mask = 8'h01;
      start = 1'b1;
      stop = 1'b1;
      tick;
      start = 1'b0;
      stop = 1'b0;
      chk("stop_start_busy", 32'(busy), 0);
      tick;
      chk_idle("stop_start_idle");

      write(2, 12'h5A5);
      ch_mask = 8'h04;
      pulse_start;
      repeat (20) tick;
      chk("pre_rst_busy", 32'(busy), 1);
      reset = 1'b0;
      #2;
      chk_idle("rst_async");
      tick;
      tick;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) mcode[i] = '0;
      pulse_start;
      run_frame(mcode[2], 2, "after_rst", -1, 0, '0);
      chk_idle("after_rst_idle");
`ifdef DAC_SCAN_STATS_EN
      repeat (2) begin
         pulse_start;
         repeat (FRAME + 2) tick;
      end
      chk("scan_count", 32'(scan_count), 3);
`endif

      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) write(c, 12'($urandom));
         msk  = 8'($urandom_range(1, 255));
         cont = 1'($urandom_range(0, 1));
         ch_mask = msk;
         continuous = cont;
         pulse_start;
         npass = cont ? 2 : 1;
         q.delete();
         for (int p = 0; p < npass; p++)
            for (int c = 0; c < 8; c++)
               if (msk[c]) q.push_back(c);
         for (int k = 0; k < q.size(); k++) begin
            last = (k == q.size() - 1) && cont;
            run_frame(mcode[q[k]], q[k], "rnd",
                      last ? $urandom_range(0, FRAME - 1) : -1,
                      last ? 1 : 0, '0);
         end
         chk_idle("rnd_idle");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
